// File: rtl/acc_mmult_seq.sv
`default_nettype none
// ============================================================================
// Module  : acc_mmult_seq
// Purpose : Sequential N x N matrix-multiply engine, C = A x B, one
//           multiply-accumulate per cycle followed by a one-cycle done pulse.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           wr_en_i/wr_sel_i/wr_addr_i/wr_data_i - operand write (sel 0=A, 1=B)
//           start_i         - start request, honoured in IDLE only
//           busy_o, done_o  - computing / one-cycle completion pulse
//           done_st_o       - sticky done, cleared by accepted start or clr_i
//           clr_i           - clears done_st_o and wr_err_o
//           wr_err_o        - sticky, operand write attempted while busy
//           rd_addr_i/rd_data_o - combinational read of result matrix C
// Revision: 1.0 - initial release
// ============================================================================
module acc_mmult_seq #(
  parameter  int DAT_SIZE  = 8,
  parameter  int MAT_SIZE  = 2,
  parameter  int ACC_WIDTH = 32,
  localparam int AW        = $clog2(MAT_SIZE * MAT_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic                 wr_sel_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [DAT_SIZE-1:0]  wr_data_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 done_st_o,
  input  logic                 clr_i,
  output logic                 wr_err_o,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [ACC_WIDTH-1:0] rd_data_o
);

  localparam int NN = MAT_SIZE * MAT_SIZE;
  localparam int IW = $clog2(MAT_SIZE);
  localparam int PW = 2 * DAT_SIZE;
  localparam logic [IW-1:0] LAST = IW'(MAT_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DAT_SIZE-1:0]  a_mem [NN];
  logic [DAT_SIZE-1:0]  b_mem [NN];
  logic [ACC_WIDTH-1:0] c_mem [NN];

  logic [IW-1:0]        i_cnt, j_cnt, k_cnt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [PW-1:0]        prod;
  logic [AW-1:0]        a_idx, b_idx, c_idx;
  logic                 start_acc, last_mac, wr_in_range;
  logic                 done_st_q, wr_err_q;

  // --------------------------------------------------------------------------
  // Datapath: element addressing and multiply-accumulate
  // --------------------------------------------------------------------------
  always_comb begin
    a_idx   = AW'(int'(i_cnt) * MAT_SIZE + int'(k_cnt));
    b_idx   = AW'(int'(k_cnt) * MAT_SIZE + int'(j_cnt));
    c_idx   = AW'(int'(i_cnt) * MAT_SIZE + int'(j_cnt));
    prod    = {{DAT_SIZE{1'b0}}, a_mem[a_idx]} * {{DAT_SIZE{1'b0}}, b_mem[b_idx]};
    // k==0 restarts the dot product, so acc never needs an explicit clear
    acc_nxt = (k_cnt == '0) ? ACC_WIDTH'(prod) : acc + ACC_WIDTH'(prod);
  end

  assign wr_in_range = int'(wr_addr_i) < NN;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    start_acc = 1'b0;
    last_mac  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy_o   = 1'b1;
        last_mac = (i_cnt == LAST) && (j_cnt == LAST) && (k_cnt == LAST);
        if (last_mac) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Loop counters (k innermost), accumulator and result store
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt <= '0;
      j_cnt <= '0;
      k_cnt <= '0;
      acc   <= '0;
      for (int n = 0; n < NN; n++) c_mem[n] <= '0;
    end else if (start_acc) begin
      i_cnt <= '0;
      j_cnt <= '0;
      k_cnt <= '0;
    end else if (state == S_RUN) begin
      acc <= acc_nxt;
      if (k_cnt == LAST) begin
        k_cnt        <= '0;
        c_mem[c_idx] <= acc_nxt;
        if (j_cnt == LAST) begin
          j_cnt <= '0;
          i_cnt <= (i_cnt == LAST) ? '0 : i_cnt + 1'b1;
        end else begin
          j_cnt <= j_cnt + 1'b1;
        end
      end else begin
        k_cnt <= k_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Operand store: writable outside RUN only
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NN; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
      end
    end else if (wr_en_i && (state != S_RUN) && wr_in_range) begin
      if (wr_sel_i) b_mem[wr_addr_i] <= wr_data_i;
      else          a_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky status flags; a set always takes priority over a clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q  <= 1'b0;
      done_st_q <= 1'b0;
    end else begin
      if (wr_en_i && (state == S_RUN)) wr_err_q <= 1'b1;
      else if (clr_i)                  wr_err_q <= 1'b0;

      if (done_o)                   done_st_q <= 1'b1;
      else if (start_acc || clr_i)  done_st_q <= 1'b0;
    end
  end

  // done_st_o rises together with done_o rather than one cycle later
  assign done_st_o = done_st_q | done_o;
  assign wr_err_o  = wr_err_q;
  assign rd_data_o = (int'(rd_addr_i) < NN) ? c_mem[rd_addr_i] : '0;

endmodule
`default_nettype wire

// File: tb/tb_acc_mmult_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_acc_mmult_seq
// Purpose : Self-checking bench for acc_mmult_seq (N=2). A 32-bit and a 16-bit
//           accumulator instance share all inputs; expected result matrices are
//           queued by the stimulus and compared by a monitor on done_o.
// Revision: 1.0 - initial release
// ============================================================================
module tb_acc_mmult_seq;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_sel, start, clr;
  logic [1:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic        busy, done, done_st, wr_err;
  logic [31:0] rd_data;
  logic        busy16, done16, done_st16, wr_err16;
  logic [15:0] rd_data16;
  logic        snap_req;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0][31:0] c;
    logic [3:0][15:0] c16;
    logic             chk16;
  } sb_t;

  sb_t sb[$];

  always #5 clk = ~clk;

  acc_mmult_seq #(.DAT_SIZE(8), .MAT_SIZE(2), .ACC_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .start_i(start), .busy_o(busy), .done_o(done),
    .done_st_o(done_st), .clr_i(clr), .wr_err_o(wr_err), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  acc_mmult_seq #(.DAT_SIZE(8), .MAT_SIZE(2), .ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .start_i(start), .busy_o(busy16), .done_o(done16),
    .done_st_o(done_st16), .clr_i(clr), .wr_err_o(wr_err16), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic sb_t mk(input int c0, input int c1, input int c2, input int c3);
    sb_t e;
    e.c     = {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    e.c16   = '0;
    e.chk16 = 1'b0;
    return e;
  endfunction

  // Monitor: on every done pulse (or explicit snapshot request) sweep C
  initial begin
    sb_t e;
    rd_addr = '0;
    forever begin
      @(negedge clk);
      if (done || snap_req) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk($sformatf("c[%0d]", a), rd_data, e.c[a]);
            if (e.chk16) chk($sformatf("c16[%0d]", a), 32'(rd_data16), 32'(e.c16[a]));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [1:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr_mat(input logic sel, input int v0, input int v1, input int v2, input int v3);
    wr(sel, 2'd0, 8'(v0));
    wr(sel, 2'd1, 8'(v1));
    wr(sel, 2'd2, 8'(v2));
    wr(sel, 2'd3, 8'(v3));
  endtask

  task automatic snap(input sb_t e);
    sb.push_back(e);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  // One full run. err_cyc>0 attempts an A[0] write in that RUN cycle;
  // wr_st issues a B write in the same cycle as start.
  task automatic run(input sb_t e, input int err_cyc, input logic wr_st,
                     input logic [1:0] st_addr, input logic [7:0] st_data);
    sb.push_back(e);
    start = 1'b1;
    if (wr_st) begin
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = st_addr; wr_data = st_data;
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("done_c%0d", c), 32'(done), 32'd0);
      if (c == err_cyc) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'd99;
      end
      tick();
      wr_en = 1'b0;
    end
    chk("busy_c9", 32'(busy), 32'd0);
    chk("done_c9", 32'(done), 32'd1);
    chk("done_st_c9", 32'(done_st), 32'd1);
    tick();
    chk("done_c10", 32'(done), 32'd0);
    chk("done_st_c10", 32'(done_st), 32'd1);
  endtask

  initial begin
    sb_t e1, e2, e4, ez;
    e1 = mk(19, 22, 43, 50);
    // B[3]=9: C[1] = 1*6 + 2*9 = 24, C[3] = 3*6 + 4*9 = 54
    e4 = mk(19, 24, 43, 54);
    e2 = mk(130050, 130050, 130050, 130050);
    e2.c16   = {16'd64514, 16'd64514, 16'd64514, 16'd64514};
    e2.chk16 = 1'b1;
    ez = mk(0, 0, 0, 0);
    ez.chk16 = 1'b1;

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; clr = 1'b0; snap_req = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_st", 32'(done_st), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    snap(ez);

    // Basic product
    wr_mat(1'b0, 1, 2, 3, 4);
    wr_mat(1'b1, 5, 6, 7, 8);
    run(e1, 0, 1'b0, 2'd0, 8'd0);

    // Write while busy is dropped and flagged; clr clears the flags
    run(e1, 1, 1'b0, 2'd0, 8'd0);
    chk("wr_err_set", 32'(wr_err), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("wr_err_clr", 32'(wr_err), 32'd0);
    chk("done_st_clr", 32'(done_st), 32'd0);

    // Write in the same cycle as start is used by that run
    run(e4, 0, 1'b1, 2'd3, 8'd9);
    wr(1'b1, 2'd3, 8'd8);

    // Maximum operands: 16-bit accumulator wraps silently
    wr_mat(1'b0, 255, 255, 255, 255);
    wr_mat(1'b1, 255, 255, 255, 255);
    run(e2, 0, 1'b0, 2'd0, 8'd0);

    // Reset in RUN cycle 4 aborts and clears the result
    wr_mat(1'b0, 1, 2, 3, 4);
    wr_mat(1'b1, 5, 6, 7, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    snap(ez);
    for (int c = 0; c < 12; c++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      tick();
    end

    // Start held high: runs begin at cycles 0, 10 and 20
    wr_mat(1'b0, 1, 2, 3, 4);
    wr_mat(1'b1, 5, 6, 7, 8);
    sb.push_back(e1);
    sb.push_back(e1);
    sb.push_back(e1);
    start = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 21) start = 1'b0;
      chk($sformatf("b2b_busy_%0d", cyc), 32'(busy),
          32'((cyc % 10 >= 1) && (cyc % 10 <= 8)));
      chk($sformatf("b2b_done_%0d", cyc), 32'(done), 32'(cyc % 10 == 9));
      chk($sformatf("b2b_done_st_%0d", cyc), 32'(done_st),
          32'((cyc % 10 == 9) || (cyc % 10 == 0)));
      tick();
    end
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
